universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the single-bit left shift register.
- Each of DEPTH stages holds a WIDTH-bit symbol.
- Supports shift left, shift right, rotate, parallel load, hold and synchronous clear.
- Tracks how many stages hold valid shifted-in data and emits the symbol pushed out of the far end.
- Serves as a generic serialiser/deserialiser and delay line in the shifting library.

Parameters:
- DEPTH, 8, number of stages; must be ≥ 2.
- WIDTH, 1, bits per stage (symbol width); must be ≥ 1.
- CW, $clog2(DEPTH+1), width of fill_count (derived localparam; not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  advances the register when high; hold when low (clear is exempt)
- clear  input  1  synchronous clear; ignores enable
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
- rotate  input  1  when shifting, recirculate the outgoing stage instead of taking serial_in
- serial_in  input  WIDTH  symbol entering the vacated end stage
- load_data  input  DEPTH*WIDTH  parallel load value; stage 0 = bits [WIDTH-1:0]
- out  output  DEPTH*WIDTH  register contents; stage 0 is the LSB stage
- shift_out  output  WIDTH  registered copy of the symbol dropped by the last shift
- shift_out_valid  output  1  one-cycle pulse: shift_out holds a valid dropped symbol
- fill_count  output  CW  number of valid stages, 0..DEPTH
- full  output  1  high when fill_count == DEPTH (combinational from fill_count)

Behaviour:
- Reset (async, immediate):
  - out = 0, shift_out = 0, shift_out_valid = 0, fill_count = 0, full = 0.
  - Asserting reset mid-operation aborts everything; the first active edge after reset deasserts sees an empty register.
- Priority per rising edge: reset > clear > (enable & mode).
- clear = 1: same values as reset, applied synchronously. Wins over any simultaneous mode or enable.
- enable = 0, or mode = 00: all state holds; shift_out_valid = 0.
- Every shift, load or clear updates state one clock after the inputs are sampled; outputs are registered with latency 1.
- Shift left (01), rotate = 0:
  - out <= {out[(DEPTH-1)*WIDTH-1:0], serial_in}.
  - Dropped symbol = top stage (DEPTH-1).
- Shift right (10), rotate = 0:
  - out <= {serial_in, out[DEPTH*WIDTH-1:WIDTH]}.
  - Dropped symbol = stage 0.
- Rotate = 1 during a shift:
  - The dropped stage re-enters at the vacated end; serial_in is ignored.
  - Nothing leaves, so shift_out_valid = 0, shift_out holds its value and fill_count is unchanged.
- Non-rotating shift:
  - shift_out <= dropped symbol.
  - shift_out_valid <= 1 only if full was 1 before the edge; otherwise 0, since an invalid stage was dropped.
  - fill_count saturating-increments, never exceeding DEPTH.
- Parallel load (11):
  - out <= load_data, fill_count <= DEPTH.
  - shift_out_valid <= 0; shift_out holds.
  - rotate and serial_in are ignored.
- Direction changes between consecutive shifts are legal and take effect on the next edge with no bubble.
- fill_count counts symbols entered since the last reset, clear or load, not direction-aware occupancy.

Test Plan:
1. Default params, reset=1 then 0, enable=1, mode=01, rotate=0, serial_in sequence 1,1,0,1,0,1,1 → out after each edge 00000001, 00000011, 00000110, 00001101, 00011010, 00110101, 01101011; fill_count = 7; full = 0; shift_out_valid never high.
2. Continue from (1): shift in 0, then 1 → out 11010110 with full = 1; next out 10101101 with shift_out = 1, shift_out_valid pulsing for exactly one cycle; fill_count stays 8.
3. WIDTH=4, DEPTH=4: load_data = 16'hA5C3 → out = A5C3, fill_count = 4. Then shift right with serial_in = 4'hF → out = FA5C, shift_out = 3, shift_out_valid = 1. Then rotate left → out = A5CF, shift_out_valid = 0, shift_out still 3.
4. Default params: load 8'b10000001, then rotate right twice → 11000000 then 01100000; fill_count stays 8 throughout.
5. Hold and priority:
   - enable = 0 with mode = 01 for 3 cycles → out, fill_count and shift_out unchanged.
   - enable = 1, mode = 11 with clear = 1 on the same edge → out = 0, fill_count = 0.
6. Async reset asserted mid-cycle (between edges) during a shift sequence → out, fill_count and shift_out_valid go to 0 before the next edge. After release, one shift-left with serial_in = 1 → out = 00000001, fill_count = 1.

Source files
------------

// File: rtl/universal_shift_register.sv
// DEPTH-stage, WIDTH-bit universal shift register: shift left/right, rotate, parallel load,
// hold and synchronous clear, with fill tracking and a registered shifted-out symbol.
module universal_shift_register #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic                   clear_i,
  input  logic [1:0]             mode_i,
  input  logic                   rotate_i,
  input  logic [WIDTH-1:0]       serial_in_i,
  input  logic [DEPTH*WIDTH-1:0] load_data_i,
  output logic [DEPTH*WIDTH-1:0] out_o,
  output logic [WIDTH-1:0]       shift_out_o,
  output logic                   shift_out_valid_o,
  output logic [CW-1:0]          fill_count_o,
  output logic                   full_o
);

  localparam int unsigned TW = DEPTH * WIDTH;

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeLeft  = 2'b01;
  localparam logic [1:0] ModeRight = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [TW-1:0]    out_q, out_d;
  logic [WIDTH-1:0] shift_out_q, shift_out_d;
  logic             valid_q, valid_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             full;

  logic [WIDTH-1:0] top_sym, bot_sym;
  logic [CW-1:0]    fill_inc;

  assign full     = (fill_q == CW'(DEPTH));
  assign top_sym  = out_q[TW-1 -: WIDTH];
  assign bot_sym  = out_q[WIDTH-1:0];
  // Saturating count of symbols entered since the last reset, clear or load.
  assign fill_inc = full ? fill_q : fill_q + CW'(1);

  always_comb begin
    out_d       = out_q;
    shift_out_d = shift_out_q;
    valid_d     = 1'b0;
    fill_d      = fill_q;
    if (clear_i) begin
      out_d       = '0;
      shift_out_d = '0;
      fill_d      = '0;
    end else if (enable_i) begin
      unique case (mode_i)
        ModeHold: ;
        ModeLeft: begin
          out_d = {out_q[TW-WIDTH-1:0], rotate_i ? top_sym : serial_in_i};
          if (!rotate_i) begin
            shift_out_d = top_sym;
            valid_d     = full;
            fill_d      = fill_inc;
          end
        end
        ModeRight: begin
          out_d = {rotate_i ? bot_sym : serial_in_i, out_q[TW-1:WIDTH]};
          if (!rotate_i) begin
            shift_out_d = bot_sym;
            valid_d     = full;
            fill_d      = fill_inc;
          end
        end
        ModeLoad: begin
          out_d  = load_data_i;
          fill_d = CW'(DEPTH);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_q       <= '0;
      shift_out_q <= '0;
      valid_q     <= 1'b0;
      fill_q      <= '0;
    end else begin
      out_q       <= out_d;
      shift_out_q <= shift_out_d;
      valid_q     <= valid_d;
      fill_q      <= fill_d;
    end
  end

  assign out_o             = out_q;
  assign shift_out_o       = shift_out_q;
  assign shift_out_valid_o = valid_q;
  assign fill_count_o      = fill_q;
  assign full_o            = full;

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: an 8x1 and a 4x4 instance driven step by step, with
// expected results queued at drive time and popped after each clock edge.
module tb_universal_shift_register;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [1:0]  mode;
  logic        rotate;

  logic        en_a, sin_a;
  logic [7:0]  ld_a, out_a;
  logic        so_a, vld_a, full_a;
  logic [3:0]  fill_a;

  logic        en_b;
  logic [3:0]  sin_b, so_b;
  logic [15:0] ld_b, out_b;
  logic        vld_b, full_b;
  logic [2:0]  fill_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    bit          dut_b;
    logic [15:0] out;
    int          fill;
    logic        vld;
    logic [3:0]  so;
  } exp_t;

  exp_t sb[$];

  universal_shift_register #(.DEPTH(8), .WIDTH(1)) u_dut_a (
    .clk_i             (clk),
    .reset_i           (reset),
    .enable_i          (en_a),
    .clear_i           (clear),
    .mode_i            (mode),
    .rotate_i          (rotate),
    .serial_in_i       (sin_a),
    .load_data_i       (ld_a),
    .out_o             (out_a),
    .shift_out_o       (so_a),
    .shift_out_valid_o (vld_a),
    .fill_count_o      (fill_a),
    .full_o            (full_a)
  );

  universal_shift_register #(.DEPTH(4), .WIDTH(4)) u_dut_b (
    .clk_i             (clk),
    .reset_i           (reset),
    .enable_i          (en_b),
    .clear_i           (1'b0),
    .mode_i            (mode),
    .rotate_i          (rotate),
    .serial_in_i       (sin_b),
    .load_data_i       (ld_b),
    .out_o             (out_b),
    .shift_out_o       (so_b),
    .shift_out_valid_o (vld_b),
    .fill_count_o      (fill_b),
    .full_o            (full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then pop and compare after the edge.
  task automatic step(input bit dut_b, input string tag, input logic en, input logic [1:0] md,
                      input logic rot, input logic [3:0] sin, input logic [15:0] ld,
                      input logic clr, input logic [15:0] e_out, input int e_fill,
                      input logic e_vld, input logic [3:0] e_so);
    exp_t e;
    int   depth;
    mode   = md;
    rotate = rot;
    clear  = clr;
    en_a   = dut_b ? 1'b0 : en;
    en_b   = dut_b ? en : 1'b0;
    sin_a  = sin[0];
    sin_b  = sin;
    ld_a   = ld[7:0];
    ld_b   = ld;
    e.tag = tag; e.dut_b = dut_b; e.out = e_out; e.fill = e_fill; e.vld = e_vld; e.so = e_so;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    depth = e.dut_b ? 4 : 8;
    if (e.dut_b) begin
      check_eq({e.tag, ".out"},   32'(out_b),  32'(e.out));
      check_eq({e.tag, ".fill"},  32'(fill_b), 32'(e.fill));
      check_eq({e.tag, ".full"},  32'(full_b), 32'(e.fill == depth));
      check_eq({e.tag, ".valid"}, 32'(vld_b),  32'(e.vld));
      check_eq({e.tag, ".so"},    32'(so_b),   32'(e.so));
    end else begin
      check_eq({e.tag, ".out"},   32'(out_a),  32'(e.out));
      check_eq({e.tag, ".fill"},  32'(fill_a), 32'(e.fill));
      check_eq({e.tag, ".full"},  32'(full_a), 32'(e.fill == depth));
      check_eq({e.tag, ".valid"}, 32'(vld_a),  32'(e.vld));
      check_eq({e.tag, ".so"},    32'(so_a),   32'(e.so[0]));
    end
  endtask

  logic [7:0] t1_out [7];
  logic       t1_sin [7];

  initial begin
    t1_sin = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    t1_out = '{8'h01, 8'h03, 8'h06, 8'h0D, 8'h1A, 8'h35, 8'h6B};
    reset = 1'b1; clear = 1'b0; mode = 2'b00; rotate = 1'b0;
    en_a = 1'b0; en_b = 1'b0; sin_a = 1'b0; sin_b = '0; ld_a = '0; ld_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset.out",   32'(out_a),  32'h0);
    check_eq("reset.fill",  32'(fill_a), 32'h0);
    check_eq("reset.full",  32'(full_a), 32'h0);
    check_eq("reset.valid", 32'(vld_a),  32'h0);
    check_eq("reset.so",    32'(so_a),   32'h0);
    check_eq("reset.out_b", 32'(out_b),  32'h0);
    #4 reset = 1'b0;
    @(posedge clk);
    #1;

    // Fill from empty: nothing valid drops out.
    for (int i = 0; i < 7; i++)
      step(0, $sformatf("shl%0d", i), 1, 2'b01, 0, {3'b0, t1_sin[i]}, '0, 0,
           {8'h0, t1_out[i]}, i + 1, 0, 4'h0);

    step(0, "shl7",    1, 2'b01, 0, 4'h0, '0, 0, 16'h00D6, 8, 0, 4'h0);
    step(0, "shl8",    1, 2'b01, 0, 4'h1, '0, 0, 16'h00AD, 8, 1, 4'h1);
    step(0, "pulse",   1, 2'b00, 0, 4'h0, '0, 0, 16'h00AD, 8, 0, 4'h1);

    for (int i = 0; i < 3; i++)
      step(0, $sformatf("hold%0d", i), 0, 2'b01, 0, 4'h0, '0, 0, 16'h00AD, 8, 0, 4'h1);
    step(0, "clr",     1, 2'b11, 0, 4'h1, 16'h00FF, 1, 16'h0000, 0, 0, 4'h0);

    step(0, "load_a",  1, 2'b11, 1, 4'h1, 16'h0081, 0, 16'h0081, 8, 0, 4'h0);
    step(0, "rotr0",   1, 2'b10, 1, 4'h0, '0, 0, 16'h00C0, 8, 0, 4'h0);
    step(0, "rotr1",   1, 2'b10, 1, 4'h0, '0, 0, 16'h0060, 8, 0, 4'h0);

    step(1, "load_b",  1, 2'b11, 0, 4'h0, 16'hA5C3, 0, 16'hA5C3, 4, 0, 4'h0);
    step(1, "shr_b",   1, 2'b10, 0, 4'hF, '0, 0, 16'hFA5C, 4, 1, 4'h3);
    step(1, "rotl_b",  1, 2'b01, 1, 4'h0, '0, 0, 16'hA5CF, 4, 0, 4'h3);

    step(0, "pre_rst", 1, 2'b01, 0, 4'h1, '0, 0, 16'h00C1, 8, 1, 4'h0);
    // Asynchronous reset between edges must take effect without a clock.
    #2 reset = 1'b1;
    #1;
    check_eq("arst.out",   32'(out_a),  32'h0);
    check_eq("arst.fill",  32'(fill_a), 32'h0);
    check_eq("arst.valid", 32'(vld_a),  32'h0);
    check_eq("arst.out_b", 32'(out_b),  32'h0);
    #1 reset = 1'b0;
    step(0, "post_rst", 1, 2'b01, 0, 4'h1, '0, 0, 16'h0001, 1, 0, 4'h0);

    check_eq("sb.empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
